// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming SECDED codec.
//   par_w(data_w) : number of Hamming parity bits for a payload width
//   cw_w(data_w)  : full codeword width (payload + parity + overall parity)
//   is_pow2(v)    : true when v is a power of two (parity bit positions)
//   mode_e        : transaction mode, encode or decode
package hamming_pkg;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    // Smallest p with 2^p >= data_w + p + 1; scanned downward so the last hit is the smallest.
    function automatic int par_w(input int data_w);
        int p;
        p = 0;
        for (int k = 7; k >= 1; k--) begin
            if ((32'sd1 << k) >= (data_w + k + 32'sd1)) begin
                p = k;
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

    function automatic int cw_w(input int data_w);
        return data_w + par_w(data_w) + 32'sd1;
    endfunction

    function automatic logic is_pow2(input int v);
        return (v > 32'sd0) && ((v & (v - 32'sd1)) == 32'sd0);
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome / overall parity generator.
//   cw_i  : codeword (positions 1..CW_W-1 Hamming bits, bit 0 overall parity)
//   syn_o : XOR of the indices of all set bits in positions 1..CW_W-1
//   par_o : XOR of all CW_W bits
// With parity positions zeroed, syn_o is exactly the set of parity bits an
// encoder must insert, so one instance serves both encode and decode.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int PAR_W  = par_w(DATA_W),
    localparam int CW_W   = cw_w(DATA_W)
) (
    input  logic [CW_W-1:0]  cw_i,
    output logic [PAR_W-1:0] syn_o,
    output logic             par_o
);

    // Fold every set position index into the syndrome and reduce overall parity.
    always_comb begin
        syn_o = '0;
        for (int i = 1; i < CW_W; i++) begin
            if (cw_i[i]) begin
                syn_o = syn_o ^ i[PAR_W-1:0];
            end else begin
                syn_o = syn_o;
            end
        end
        par_o = ^cw_i;
    end

endmodule

// File: rtl/hamming_secded_codec.sv
// Two-stage pipelined Hamming SECDED encoder/decoder with valid/ready
// handshakes on both sides and saturating error counters.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake; in_mode 0=encode 1=decode
//   in_data               : encode payload (low DATA_W bits) or codeword
//   out_valid/out_ready   : output handshake; out_mode echoes the mode
//   out_data              : codeword, or corrected payload zero-extended
//   out_err_sgl/_dbl      : decode corrected / uncorrectable flags
//   cnt_clr               : synchronous clear of both counters
//   sgl_cnt/dbl_cnt       : saturating counts of accepted flagged results
module hamming_secded_codec
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 16,
    localparam int PAR_W  = par_w(DATA_W),
    localparam int CW_W   = cw_w(DATA_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [CW_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [CW_W-1:0]  out_data,
    output logic             out_err_sgl,
    output logic             out_err_dbl,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] sgl_cnt,
    output logic [CNT_W-1:0] dbl_cnt
);

    localparam logic [PAR_W-1:0] MAX_POS = PAR_W'(CW_W - 1);

    // Place payload bits into the non-power-of-two positions, parity slots zero.
    function automatic logic [CW_W-1:0] scatter(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] c;
        int j;
        c = '0;
        j = 0;
        for (int i = 1; i < CW_W; i++) begin
            if (!is_pow2(i)) begin
                c[i] = d[j];
                j++;
            end else begin
                c[i] = 1'b0;
            end
        end
        return c;
    endfunction

    // Pull payload bits back out of the non-power-of-two positions.
    function automatic logic [DATA_W-1:0] gather(input logic [CW_W-1:0] c);
        logic [DATA_W-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int i = 1; i < CW_W; i++) begin
            if (!is_pow2(i)) begin
                d[j] = c[i];
                j++;
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

    logic              s1_valid_q;
    mode_e             s1_mode_q;
    logic [CW_W-1:0]   s1_cw_q;
    logic [PAR_W-1:0]  s1_syn_q;
    logic              s1_par_q;

    logic              out_valid_q;
    mode_e             out_mode_q;
    logic [CW_W-1:0]   out_data_q;
    logic              out_sgl_q;
    logic              out_dbl_q;
    logic [CNT_W-1:0]  sgl_cnt_q;
    logic [CNT_W-1:0]  dbl_cnt_q;

    logic [CW_W-1:0]   s1_cw_d;
    logic [PAR_W-1:0]  syn_s;
    logic              par_s;
    logic              s2_ready_s;
    logic [CW_W-1:0]   res_cw_s;
    logic [CW_W-1:0]   res_data_s;
    logic              res_sgl_s;
    logic              res_dbl_s;
    logic              out_fire_s;

    // S2 can take a new word when empty or when its word leaves this cycle.
    assign s2_ready_s = !out_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s2_ready_s;
    assign out_fire_s = out_valid_q && out_ready;

    // Encode feeds the scattered payload so the syndrome equals the parity to insert.
    always_comb begin
        if (in_mode == MODE_DEC) begin
            s1_cw_d = in_data;
        end else begin
            s1_cw_d = scatter(in_data[DATA_W-1:0]);
        end
    end

    hamming_syndrome #(
        .DATA_W (DATA_W)
    ) u_syndrome (
        .cw_i  (s1_cw_d),
        .syn_o (syn_s),
        .par_o (par_s)
    );

    // Stage 1: register the word, its mode and its syndrome/parity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= MODE_ENC;
            s1_cw_q    <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end else begin
                s1_valid_q <= s1_valid_q;
            end
            if (in_valid && in_ready) begin
                s1_mode_q <= mode_e'(in_mode);
                s1_cw_q   <= s1_cw_d;
                s1_syn_q  <= syn_s;
                s1_par_q  <= par_s;
            end else begin
                s1_mode_q <= s1_mode_q;
                s1_cw_q   <= s1_cw_q;
                s1_syn_q  <= s1_syn_q;
                s1_par_q  <= s1_par_q;
            end
        end
    end

    // Stage 2 datapath: insert parity (encode) or correct and extract (decode).
    always_comb begin
        res_cw_s   = s1_cw_q;
        res_data_s = '0;
        res_sgl_s  = 1'b0;
        res_dbl_s  = 1'b0;
        case (s1_mode_q)
            MODE_ENC: begin
                for (int i = 1, int j = 0; i < CW_W; i++) begin
                    if (is_pow2(i)) begin
                        res_cw_s[i] = s1_syn_q[j];
                        j++;
                    end else begin
                        res_cw_s[i] = s1_cw_q[i];
                    end
                end
                res_cw_s[0] = ^res_cw_s[CW_W-1:1];
                res_data_s  = res_cw_s;
            end
            MODE_DEC: begin
                if (s1_par_q) begin
                    // Odd parity: a syndrome past the last position cannot be a single error.
                    if (s1_syn_q > MAX_POS) begin
                        res_dbl_s = 1'b1;
                    end else begin
                        res_sgl_s = 1'b1;
                        for (int i = 0; i < CW_W; i++) begin
                            if (s1_syn_q == i[PAR_W-1:0]) begin
                                res_cw_s[i] = ~s1_cw_q[i];
                            end else begin
                                res_cw_s[i] = s1_cw_q[i];
                            end
                        end
                    end
                end else if (s1_syn_q != '0) begin
                    res_dbl_s = 1'b1;
                end else begin
                    res_dbl_s = 1'b0;
                end
                res_data_s = {{(CW_W-DATA_W){1'b0}}, gather(res_cw_s)};
            end
            default: begin
                res_data_s = '0;
            end
        endcase
    end

    // Stage 2 registers: hold the presented result while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_mode_q  <= MODE_ENC;
            out_data_q  <= '0;
            out_sgl_q   <= 1'b0;
            out_dbl_q   <= 1'b0;
        end else begin
            if (s2_ready_s) begin
                out_valid_q <= s1_valid_q;
            end else begin
                out_valid_q <= out_valid_q;
            end
            if (s2_ready_s && s1_valid_q) begin
                out_mode_q <= s1_mode_q;
                out_data_q <= res_data_s;
                out_sgl_q  <= res_sgl_s;
                out_dbl_q  <= res_dbl_s;
            end else begin
                out_mode_q <= out_mode_q;
                out_data_q <= out_data_q;
                out_sgl_q  <= out_sgl_q;
                out_dbl_q  <= out_dbl_q;
            end
        end
    end

    // Single-error counter: counts accepted corrected decodes, saturates, clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgl_cnt_q <= '0;
        end else if (cnt_clr) begin
            sgl_cnt_q <= '0;
        end else if (out_fire_s && (out_mode_q == MODE_DEC) && out_sgl_q && (sgl_cnt_q != '1)) begin
            sgl_cnt_q <= sgl_cnt_q + CNT_W'(1);
        end else begin
            sgl_cnt_q <= sgl_cnt_q;
        end
    end

    // Double-error counter: counts accepted uncorrectable decodes, saturates, clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbl_cnt_q <= '0;
        end else if (cnt_clr) begin
            dbl_cnt_q <= '0;
        end else if (out_fire_s && (out_mode_q == MODE_DEC) && out_dbl_q && (dbl_cnt_q != '1)) begin
            dbl_cnt_q <= dbl_cnt_q + CNT_W'(1);
        end else begin
            dbl_cnt_q <= dbl_cnt_q;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_mode    = out_mode_q;
    assign out_data    = out_data_q;
    assign out_err_sgl = out_sgl_q;
    assign out_err_dbl = out_dbl_q;
    assign sgl_cnt     = sgl_cnt_q;
    assign dbl_cnt     = dbl_cnt_q;

endmodule
